// File: rtl/z3_bus_arbiter.sv
// z3_bus_arbiter: Zorro III central bus arbiter. Decodes per-slot BR_n
// registration pulses and hands the bus CPU <-> slots round-robin.
//
// Ports:
//   clk          arbiter clock, all inputs synchronous to it
//   IORST_n      asynchronous active-low reset
//   BR_n         per-slot registration pulse (falling edge toggles slot)
//   FCS_n        full cycle strobe, active low
//   DTACK_n      data acknowledge, active low
//   BG_n         per-slot bus grant, active low, at most one low
//   CPU_BG_n     CPU grant, active low (low only while CPU owns the bus)
//   reg_mask     current registration bits
//   owner        granted slot index, valid while grant_active
//   grant_active high while a slot holds the grant
module z3_bus_arbiter #(
    parameter int NSLOTS  = 5,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              IORST_n,
    input  logic [NSLOTS-1:0] BR_n,
    input  logic              FCS_n,
    input  logic              DTACK_n,
    output logic [NSLOTS-1:0] BG_n,
    output logic              CPU_BG_n,
    output logic [NSLOTS-1:0] reg_mask,
    output logic [2:0]        owner,
    output logic              grant_active
);

    typedef enum logic [1:0] {
        S_CPU,
        S_GAP,
        S_GRANT
    } state_t;

    state_t            state;
    logic [NSLOTS-1:0] br_q;
    logic [2:0]        ptr;
    logic              cycle_seen;
    logic [7:0]        idle_cnt;

    logic              bus_idle;
    logic [7:0]        mask8;
    logic [3:0]        sum;
    logic [2:0]        idx;
    logic              found;
    logic [2:0]        next_slot;
    logic [2:0]        ptr_nxt;
    logic [NSLOTS-1:0] next_oh;
    logic [NSLOTS-1:0] own_oh;
    logic              others;
    logic              drop;

    assign bus_idle = FCS_n & DTACK_n;

    // Round-robin pick: first registered slot at or above ptr, wrapping.
    always_comb begin
        mask8     = 8'(reg_mask);
        next_slot = '0;
        found     = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int i = 0; i < NSLOTS; i++) begin
            sum = {1'b0, ptr} + 4'(i);
            if (sum >= 4'(NSLOTS))
                idx = 3'(sum - 4'(NSLOTS));
            else
                idx = 3'(sum);
            if (!found && mask8[idx]) begin
                found     = 1'b1;
                next_slot = idx;
            end
        end
    end

    assign ptr_nxt = (next_slot == 3'(NSLOTS - 1)) ? 3'd0
                                                  : next_slot + 3'd1;
    assign next_oh = NSLOTS'(8'd1 << next_slot);
    assign own_oh  = NSLOTS'(8'd1 << owner);
    assign others  = |(reg_mask & ~own_oh);

    // Release reasons: owner unregistered, or it has had its turn
    // (a cycle ran or it sat idle too long) while someone else waits.
    assign drop = ~mask8[owner]
                | (cycle_seen & others)
                | ((idle_cnt == 8'(TIMEOUT)) & others);

    // A held-low BR_n only contributes on the clock it first goes low.
    always_ff @(posedge clk or negedge IORST_n) begin
        if (!IORST_n) begin
            br_q     <= '1;
            reg_mask <= '0;
        end else begin
            br_q     <= BR_n;
            reg_mask <= reg_mask ^ (br_q & ~BR_n);
        end
    end

    always_ff @(posedge clk or negedge IORST_n) begin
        if (!IORST_n) begin
            state        <= S_CPU;
            CPU_BG_n     <= 1'b0;
            BG_n         <= '1;
            ptr          <= '0;
            owner        <= '0;
            grant_active <= 1'b0;
            cycle_seen   <= 1'b0;
            idle_cnt     <= '0;
        end else begin
            unique case (state)
                S_CPU: begin
                    if ((|reg_mask) && bus_idle) begin
                        state    <= S_GAP;
                        CPU_BG_n <= 1'b1;
                    end
                end
                S_GAP: begin
                    if (bus_idle) begin
                        if (|reg_mask) begin
                            state        <= S_GRANT;
                            owner        <= next_slot;
                            ptr          <= ptr_nxt;
                            BG_n         <= ~next_oh;
                            grant_active <= 1'b1;
                            cycle_seen   <= 1'b0;
                            idle_cnt     <= '0;
                        end else begin
                            state    <= S_CPU;
                            CPU_BG_n <= 1'b0;
                        end
                    end
                end
                S_GRANT: begin
                    if (!FCS_n) begin
                        cycle_seen <= 1'b1;
                        idle_cnt   <= '0;
                    end else if (idle_cnt != 8'(TIMEOUT)) begin
                        idle_cnt <= idle_cnt + 8'd1;
                    end
                    if (bus_idle && drop) begin
                        state        <= S_GAP;
                        BG_n         <= '1;
                        grant_active <= 1'b0;
                    end
                end
                default: begin
                    state        <= S_CPU;
                    CPU_BG_n     <= 1'b0;
                    BG_n         <= '1;
                    grant_active <= 1'b0;
                end
            endcase
        end
    end

endmodule
